qdr_user_app_responder: RTL and testbench
=========================================

Name: qdr_user_app_responder

Overview:
- Synthesizable stand-in for the QDR-II+ controller user-app port, seen from the memory side.
- Accepts the wr_cmd/rd_cmd stream that dflow_generator_core issues and answers with rd_valid/rd_data at a fixed latency.
- Backed by on-chip RAM, so dflow store/replay can run in simulation and on boards without QDR fitted.
- Sits between dflow_generator_core and the top-level user_app_*0 pins, in place of the MIG user interface.

Parameters:
- DATA_WIDTH, 144: user-app data word width (QDR_BURST_LENGTH x QDR_DATA_WIDTH).
- ADDR_WIDTH, 19: user-app address width.
- MEM_DEPTH_LOG2, 12: implemented RAM depth in words; upper address bits alias.
- RD_LATENCY, 8: cycles from rd_cmd to rd_valid; legal range 2..32.
- CALIB_CYCLES, 64: cycles after reset release before init_calib_complete rises; legal range 1..65535.

Ports:
- qdr_clk  in  1  user-app clock.
- resetn  in  1  reset.
- init_calib_complete  out  1  memory ready.
- user_app_wr_cmd  in  1  write strobe, one word per cycle.
- user_app_wr_addr  in  ADDR_WIDTH  write address.
- user_app_wr_data  in  DATA_WIDTH  write data.
- user_app_rd_cmd  in  1  read strobe, one word per cycle.
- user_app_rd_addr  in  ADDR_WIDTH  read address.
- user_app_rd_valid  out  1  read data valid.
- user_app_rd_data  out  DATA_WIDTH  read data.
- wr_count  out  32  accepted writes since reset.
- rd_count  out  32  accepted reads since reset.
- cmd_drop_count  out  16  commands dropped before calibration completed.
- alias_err  out  1  sticky: an address with nonzero bits above MEM_DEPTH_LOG2 was seen.

Behaviour:
- Reset: reset resetn, synchronous, active-low; clock qdr_clk.
  - While resetn=0: init_calib_complete=0, user_app_rd_valid=0, user_app_rd_data=0, all counters=0, alias_err=0.
  - All rd pipeline stages are cleared.
  - RAM contents are not cleared.
- Calibration FSM:
  - States: CALIB, READY.
  - CALIB: a 16-bit counter increments each cycle; at count==CALIB_CYCLES-1 the FSM moves to READY.
  - init_calib_complete is registered and equals (state==READY). It first reads 1 exactly CALIB_CYCLES cycles after the first cycle with resetn=1.
  - READY is held until reset.
- Commands in CALIB:
  - A cycle with wr_cmd or rd_cmd asserted increments cmd_drop_count by 1 if only one is asserted, by 2 if both are.
  - cmd_drop_count saturates at 0xFFFF.
  - No RAM write, no read response.
- Write (READY, wr_cmd=1):
  - RAM[wr_addr[MEM_DEPTH_LOG2-1:0]] <= wr_data at the clock edge.
  - wr_count += 1, wrapping modulo 2^32.
- Read (READY, rd_cmd=1):
  - RAM is read synchronously in read-first mode: a same-cycle write to the same address returns the old data.
  - A read issued one or more cycles after a write to that address returns the new data.
  - rd_count += 1, wrapping.
  - Valid and data then pass through a delay line so that rd_valid=1 exactly RD_LATENCY cycles after the rd_cmd cycle, for exactly one cycle per command.
  - Back-to-back reads give back-to-back rd_valid in issue order.
  - No backpressure exists: every accepted read returns.
- rd_data is held at the last returned value when rd_valid=0.
- Simultaneous wr_cmd and rd_cmd are both accepted in the same cycle, as on the independent QDR read and write ports.
- Aliasing:
  - A command whose address has any bit set in [ADDR_WIDTH-1:MEM_DEPTH_LOG2] still executes on the low bits.
  - That command sets alias_err, which stays set until reset.
  - Dropped commands do not set alias_err.
- Reset mid-operation:
  - In-flight reads are discarded and no rd_valid appears after reset.
  - The FSM returns to CALIB.
  - RAM keeps its data.

Decomposition:
- Shared package (dflow_qdr_pkg):
  - QDR_USER_DATA_WIDTH=144 and QDR_ADDR_WIDTH=19.
  - Default RD_LATENCY and CALIB_CYCLES constants.
  - A calib_state_t enum {CALIB, READY}.
- Sub-module qdr_rd_delay_line:
  - Parameterized depth RD_LATENCY-1.
  - Carries valid plus DATA_WIDTH of data.
  - Valid bits reset synchronously; data bits carry no reset.
- The top of this block holds the RAM (inferred BRAM), the FSM and the counters.

Test Plan:
- Reset, CALIB_CYCLES=64, no traffic -> init_calib_complete rises on cycle 64 after resetn release; all outputs 0 before that.
- wr_cmd at 0x00010 with data 0xA5..A5, then rd_cmd at 0x00010 two cycles later, RD_LATENCY=8 -> rd_valid exactly 8 cycles after rd_cmd with data 0xA5..A5; wr_count=1, rd_count=1.
- Write 16 consecutive addresses (data = addr), then 16 back-to-back reads -> 16 contiguous rd_valid cycles, data 0..15 in order.
- Same cycle, wr addr 5 data X and rd addr 5 (old data Y) -> returns Y; next-cycle read of addr 5 returns X.
- Three wr_cmd plus one combined wr+rd cycle during CALIB -> cmd_drop_count=5, no rd_valid, RAM location unchanged.
- MEM_DEPTH_LOG2=12: write 0x01003 with data Z -> alias_err=1; read of 0x00003 returns Z.
- Reset asserted with 4 reads in flight -> no rd_valid after reset; init_calib_complete=0 for 64 cycles; data written before reset is still readable after recalibration.

Source files
------------

// File: rtl/dflow_qdr_pkg.sv
// Shared definitions for the dflow QDR-II+ user-app path.
// Holds the user-app word/address widths, the default read latency and
// calibration length used by the on-chip responder, and the calibration
// state type.
package dflow_qdr_pkg;

  localparam int QDR_USER_DATA_WIDTH      = 144;
  localparam int QDR_ADDR_WIDTH           = 19;
  localparam int QDR_DEFAULT_RD_LATENCY   = 8;
  localparam int QDR_DEFAULT_CALIB_CYCLES = 64;

  typedef enum logic {
    CALIB = 1'b0,
    READY = 1'b1
  } calib_state_t;

endpackage

// File: rtl/qdr_rd_delay_line.sv
// Fixed-depth delay line for read responses.
// Ports:
//   qdr_clk  - clock
//   resetn   - synchronous active-low reset, clears the valid bits only
//   in_vld   - response valid entering the line
//   in_data  - response data entering the line
//   out_vld  - valid after DEPTH cycles
//   out_data - data after DEPTH cycles
module qdr_rd_delay_line
  import dflow_qdr_pkg::*;
#(
  parameter int DEPTH      = QDR_DEFAULT_RD_LATENCY - 1,
  parameter int DATA_WIDTH = QDR_USER_DATA_WIDTH
) (
  input  logic                  qdr_clk,
  input  logic                  resetn,
  input  logic                  in_vld,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_vld,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic [DEPTH-1:0]      vld_q;
  logic [DEPTH-1:0]      vld_d;
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_d [DEPTH];

  always_comb begin
    vld_d     = '0;
    data_d[0] = in_data;
    vld_d[0]  = in_vld;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i]  = vld_q[i-1];
      data_d[i] = data_q[i-1];
    end
  end

  always_ff @(posedge qdr_clk) begin
    if (!resetn) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  // Data needs no reset: it is only observed when the matching valid is set.
  always_ff @(posedge qdr_clk) begin
    data_q <= data_d;
  end

  assign out_vld  = vld_q[DEPTH-1];
  assign out_data = data_q[DEPTH-1];

endmodule

// File: rtl/qdr_user_app_responder.sv
// On-chip stand-in for the QDR-II+ controller user-app port.
// Accepts the write/read command streams, stores writes in an inferred RAM
// and answers each read with rd_valid/rd_data a fixed RD_LATENCY cycles later.
// Ports:
//   qdr_clk, resetn          - clock, synchronous active-low reset
//   init_calib_complete      - high once the emulated calibration has finished
//   user_app_wr_cmd/addr/data - write port, one word per cycle
//   user_app_rd_cmd/addr     - read port, one word per cycle
//   user_app_rd_valid/data   - read response; data holds between responses
//   wr_count, rd_count       - accepted writes/reads since reset (wrapping)
//   cmd_drop_count           - commands ignored before calibration (saturating)
//   alias_err                - sticky: an accepted address used bits above the RAM
module qdr_user_app_responder
  import dflow_qdr_pkg::*;
#(
  parameter int DATA_WIDTH     = QDR_USER_DATA_WIDTH,
  parameter int ADDR_WIDTH     = QDR_ADDR_WIDTH,
  parameter int MEM_DEPTH_LOG2 = 12,
  parameter int RD_LATENCY     = QDR_DEFAULT_RD_LATENCY,
  parameter int CALIB_CYCLES   = QDR_DEFAULT_CALIB_CYCLES
) (
  input  logic                  qdr_clk,
  input  logic                  resetn,
  output logic                  init_calib_complete,
  input  logic                  user_app_wr_cmd,
  input  logic [ADDR_WIDTH-1:0] user_app_wr_addr,
  input  logic [DATA_WIDTH-1:0] user_app_wr_data,
  input  logic                  user_app_rd_cmd,
  input  logic [ADDR_WIDTH-1:0] user_app_rd_addr,
  output logic                  user_app_rd_valid,
  output logic [DATA_WIDTH-1:0] user_app_rd_data,
  output logic [31:0]           wr_count,
  output logic [31:0]           rd_count,
  output logic [15:0]           cmd_drop_count,
  output logic                  alias_err
);

  localparam int          MEM_DEPTH  = 1 << MEM_DEPTH_LOG2;
  localparam logic [15:0] CALIB_LAST = 16'(CALIB_CYCLES - 1);

  function automatic logic addr_aliases(input logic [ADDR_WIDTH-1:0] a);
    return (a >> MEM_DEPTH_LOG2) != '0;
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Calibration FSM
  calib_state_t state_q;
  logic [15:0]  calib_cnt_q;
  logic         init_calib_complete_q;

  always_ff @(posedge qdr_clk) begin
    if (!resetn) begin
      state_q               <= CALIB;
      calib_cnt_q           <= '0;
      init_calib_complete_q <= 1'b0;
    end else begin
      case (state_q)
        CALIB: begin
          calib_cnt_q <= calib_cnt_q + 16'd1;
          if (calib_cnt_q == CALIB_LAST) begin
            state_q               <= READY;
            init_calib_complete_q <= 1'b1;
          end
        end
        READY: init_calib_complete_q <= 1'b1;
        default: state_q <= CALIB;
      endcase
    end
  end

  logic                      ready;
  logic                      wr_acc;
  logic                      rd_acc;
  logic [MEM_DEPTH_LOG2-1:0] wr_idx;
  logic [MEM_DEPTH_LOG2-1:0] rd_idx;

  assign ready  = (state_q == READY);
  assign wr_acc = ready & user_app_wr_cmd;
  assign rd_acc = ready & user_app_rd_cmd;
  assign wr_idx = user_app_wr_addr[MEM_DEPTH_LOG2-1:0];
  assign rd_idx = user_app_rd_addr[MEM_DEPTH_LOG2-1:0];

  // Backing RAM. Write and registered read share the edge, so a read of the
  // address being written in the same cycle returns the previous contents.
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] ram_rd_data_q;

  always_ff @(posedge qdr_clk) begin
    if (wr_acc) begin
      mem[wr_idx] <= user_app_wr_data;
    end
  end

  always_ff @(posedge qdr_clk) begin
    if (rd_acc) begin
      ram_rd_data_q <= mem[rd_idx];
    end
  end

  // Counters, sticky alias flag, first read stage valid and output hold
  logic [31:0]           wr_count_d, wr_count_q;
  logic [31:0]           rd_count_d, rd_count_q;
  logic [15:0]           cmd_drop_count_d, cmd_drop_count_q;
  logic                  alias_err_d, alias_err_q;
  logic                  ram_rd_vld_d, ram_rd_vld_q;
  logic [DATA_WIDTH-1:0] rd_hold_d, rd_hold_q;
  logic                  dl_vld;
  logic [DATA_WIDTH-1:0] dl_data;

  always_comb begin
    wr_count_d       = wr_count_q + {31'd0, wr_acc};
    rd_count_d       = rd_count_q + {31'd0, rd_acc};
    cmd_drop_count_d = cmd_drop_count_q;
    if (!ready) begin
      cmd_drop_count_d = sat_add16(cmd_drop_count_q,
                                   {1'b0, user_app_wr_cmd} + {1'b0, user_app_rd_cmd});
    end
    alias_err_d = alias_err_q
                | (wr_acc & addr_aliases(user_app_wr_addr))
                | (rd_acc & addr_aliases(user_app_rd_addr));
    ram_rd_vld_d = rd_acc;
    rd_hold_d    = dl_vld ? dl_data : rd_hold_q;
  end

  always_ff @(posedge qdr_clk) begin
    if (!resetn) begin
      wr_count_q       <= '0;
      rd_count_q       <= '0;
      cmd_drop_count_q <= '0;
      alias_err_q      <= 1'b0;
      ram_rd_vld_q     <= 1'b0;
      rd_hold_q        <= '0;
    end else begin
      wr_count_q       <= wr_count_d;
      rd_count_q       <= rd_count_d;
      cmd_drop_count_q <= cmd_drop_count_d;
      alias_err_q      <= alias_err_d;
      ram_rd_vld_q     <= ram_rd_vld_d;
      rd_hold_q        <= rd_hold_d;
    end
  end

  // The RAM output register is the first of RD_LATENCY stages; the delay
  // line supplies the rest and its last stage drives rd_valid directly.
  qdr_rd_delay_line #(
    .DEPTH      (RD_LATENCY - 1),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rd_delay (
    .qdr_clk  (qdr_clk),
    .resetn   (resetn),
    .in_vld   (ram_rd_vld_q),
    .in_data  (ram_rd_data_q),
    .out_vld  (dl_vld),
    .out_data (dl_data)
  );

  assign init_calib_complete = init_calib_complete_q;
  assign user_app_rd_valid   = dl_vld;
  // Present new data in its valid cycle, otherwise the last returned word.
  assign user_app_rd_data    = dl_vld ? dl_data : rd_hold_q;
  assign wr_count            = wr_count_q;
  assign rd_count            = rd_count_q;
  assign cmd_drop_count      = cmd_drop_count_q;
  assign alias_err           = alias_err_q;

endmodule

// File: tb/tb_qdr_user_app_responder.sv
module tb_qdr_user_app_responder;

  localparam int DW = 144;
  localparam int AW = 19;
  localparam int ML = 12;
  localparam int RL = 8;
  localparam int CC = 64;
  localparam int MEM_WORDS = 1 << ML;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          init_calib_complete;
  logic          wr_cmd = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_cmd = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [31:0]   wr_count;
  logic [31:0]   rd_count;
  logic [15:0]   cmd_drop_count;
  logic          alias_err;

  always #5 clk = ~clk;

  qdr_user_app_responder #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .MEM_DEPTH_LOG2 (ML),
    .RD_LATENCY     (RL),
    .CALIB_CYCLES   (CC)
  ) dut (
    .qdr_clk             (clk),
    .resetn              (resetn),
    .init_calib_complete (init_calib_complete),
    .user_app_wr_cmd     (wr_cmd),
    .user_app_wr_addr    (wr_addr),
    .user_app_wr_data    (wr_data),
    .user_app_rd_cmd     (rd_cmd),
    .user_app_rd_addr    (rd_addr),
    .user_app_rd_valid   (rd_valid),
    .user_app_rd_data    (rd_data),
    .wr_count            (wr_count),
    .rd_count            (rd_count),
    .cmd_drop_count      (cmd_drop_count),
    .alias_err           (alias_err)
  );

  typedef struct {
    int            exp_edge;
    logic [DW-1:0] data;
    bit            known;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            edges = 0;
  int            checks = 0;
  int            failures = 0;
  logic [DW-1:0] mem_m [int];
  int unsigned   wr_m = 0;
  int unsigned   rd_m = 0;
  int            drop_m = 0;
  bit            alias_m = 1'b0;
  bit            en_chk = 1'b0;
  int            rel_edge = 0;
  logic [DW-1:0] last_m = '0;

  always @(posedge clk) edges <= edges + 1;

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Monitor: every response is matched against the oldest pending read
  always @(negedge clk) begin
    if (en_chk) check("init_calib", DW'(init_calib_complete), DW'((edges - rel_edge) >= CC));
    if (rd_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rd_valid actual=1 required=0 at edge %0d", edges);
      end else begin
        mon_e = sb.pop_front();
        check("rd_latency", DW'(edges), DW'(mon_e.exp_edge));
        if (mon_e.known) check("rd_data", rd_data, mon_e.data);
        last_m = mon_e.known ? mon_e.data : rd_data;
      end
    end else if (en_chk) begin
      check("rd_hold", rd_data, last_m);
    end
  end

  function automatic logic [DW-1:0] rand_word();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return r[DW-1:0];
  endfunction

  function automatic bit model_ready();
    return en_chk && ((edges - rel_edge) >= CC);
  endfunction

  // Drive one command cycle and update the reference model
  task automatic issue(input bit w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input bit r, input logic [AW-1:0] ra);
    exp_t e;
    int   wi;
    int   ri;
    wi = int'(wa) % MEM_WORDS;
    ri = int'(ra) % MEM_WORDS;
    wr_cmd = w; wr_addr = wa; wr_data = wd;
    rd_cmd = r; rd_addr = ra;
    if (model_ready()) begin
      if (r) begin
        e.exp_edge = edges + RL;
        e.known    = mem_m.exists(ri);
        e.data     = '0;
        if (e.known) e.data = mem_m[ri];
        sb.push_back(e);
        rd_m++;
        if (int'(ra) >= MEM_WORDS) alias_m = 1'b1;
      end
      if (w) begin
        mem_m[wi] = wd;
        wr_m++;
        if (int'(wa) >= MEM_WORDS) alias_m = 1'b1;
      end
    end else begin
      drop_m = drop_m + int'(w) + int'(r);
      if (drop_m > 65535) drop_m = 65535;
    end
    @(posedge clk); #1;
    wr_cmd = 1'b0;
    rd_cmd = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_wr_count"}, DW'(wr_count), DW'(wr_m));
    check({tag, "_rd_count"}, DW'(rd_count), DW'(rd_m));
    check({tag, "_drop_count"}, DW'(cmd_drop_count), DW'(drop_m));
    check({tag, "_alias_err"}, DW'(alias_err), DW'(alias_m));
  endtask

  task automatic assert_reset();
    int keep[$];
    en_chk = 1'b0;
    resetn = 1'b0;
    // Responses due after the reset edge must never appear
    while (sb.size() > 0 && sb[sb.size()-1].exp_edge > edges) void'(sb.pop_back());
    keep.delete();
    wr_m = 0; rd_m = 0; drop_m = 0; alias_m = 1'b0;
    idle(3);
    check("rst_init", DW'(init_calib_complete), '0);
    check("rst_rd_valid", DW'(rd_valid), '0);
    check("rst_rd_data", rd_data, '0);
    check_counts("rst");
  endtask

  task automatic release_reset();
    resetn   = 1'b1;
    rel_edge = edges;
    last_m   = '0;
    en_chk   = 1'b1;
  endtask

  task automatic wait_ready();
    int budget;
    budget = 0;
    while (!model_ready() && budget < CC + 10) begin
      idle(1);
      budget++;
    end
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (sb.size() > 0 && budget < RL + 20) begin
      idle(1);
      budget++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain_pending actual=%0d required=0", sb.size());
    end
  endtask

  logic [AW-1:0] a;
  logic [DW-1:0] z;

  initial begin
    idle(1);
    assert_reset();
    release_reset();

    // Commands during calibration are counted and ignored
    issue(1, AW'(7), rand_word(), 0, '0);
    issue(1, AW'(7), rand_word(), 0, '0);
    issue(1, AW'(7), rand_word(), 0, '0);
    issue(1, AW'(7), rand_word(), 1, AW'(7));
    idle(2);
    check_counts("calib_drop");
    wait_ready();
    drop_m = drop_m; // drops stay as counted

    // Single write then read two cycles later
    issue(1, AW'('h10), {18{8'hA5}}, 0, '0);
    idle(1);
    issue(0, '0, '0, 1, AW'('h10));
    drain();
    check_counts("single");

    // Sixteen writes then sixteen back-to-back reads
    for (int i = 0; i < 16; i++) issue(1, AW'(i), DW'(i), 0, '0);
    for (int i = 0; i < 16; i++) issue(0, '0, '0, 1, AW'(i));
    drain();

    // Same-cycle write/read returns old data, next-cycle read the new
    z = rand_word();
    issue(1, AW'(5), z, 1, AW'(5));
    issue(0, '0, '0, 1, AW'(5));
    drain();
    check_counts("rdfirst");

    // Aliased write lands on the low bits and sets the sticky flag
    z = rand_word();
    issue(1, AW'('h01003), z, 0, '0);
    issue(0, '0, '0, 1, AW'('h00003));
    drain();
    check_counts("alias");

    // Randomised traffic over a prewritten window, occasional alias bits
    for (int i = 0; i < 64; i++) issue(1, AW'(i), rand_word(), 0, '0);
    for (int i = 0; i < 300; i++) begin
      bit w;
      bit r;
      logic [AW-1:0] wa;
      logic [AW-1:0] ra;
      w  = ($urandom_range(0, 1) == 1);
      r  = ($urandom_range(0, 2) != 0);
      wa = AW'($urandom_range(0, 63));
      ra = AW'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) wa = wa | (AW'($urandom_range(1, 127)) << ML);
      if ($urandom_range(0, 7) == 0) ra = ra | (AW'($urandom_range(1, 127)) << ML);
      issue(w, wa, rand_word(), r, ra);
    end
    drain();
    check_counts("random");

    // Reset with four reads in flight
    for (int i = 0; i < 4; i++) issue(0, '0, '0, 1, AW'(i));
    assert_reset();
    release_reset();
    issue(1, AW'(3), rand_word(), 0, '0);
    issue(1, AW'(3), rand_word(), 0, '0);
    issue(1, AW'(3), rand_word(), 0, '0);
    issue(1, AW'(3), rand_word(), 1, AW'(3));
    idle(RL + 2);
    check_counts("recal_drop");
    wait_ready();
    for (int i = 0; i < 8; i++) issue(0, '0, '0, 1, AW'(i));
    drain();
    check_counts("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
